// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the parametrised SPI slave + RAM.
//   state_t  : framing FSM states
//   CMD_*    : 2-bit command codes carried after the R/W bit
//   pw_of()  : payload width = max(ADDR_WIDTH, DATA_WIDTH)
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int pw_of(input int aw, input int dw);
    return (aw > dw) ? aw : dw;
  endfunction

endpackage

// File: rtl/spi_ram_if.sv
// SPI pin bundle.
//   SS_n : slave select, active low (master -> slave)
//   MOSI : serial data in, MSB first (master -> slave)
//   MISO : serial data out, MSB first (slave -> master)
interface spi_ram_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output MOSI, input MISO);
  modport slave  (input SS_n, input MOSI, output MISO);
endinterface

// File: rtl/spi_ram_mem.sv
// RAM and address registers behind the SPI slave.
//   clk, rst_n    : clock, async active-low reset (RAM array is not reset)
//   din[PW+1:0]   : {cmd[1:0], payload[PW-1:0]} from the rx shifter
//   rx_valid      : one-cycle strobe, din holds a complete accepted frame
//   dout          : read data (all zeros for out-of-range addresses)
//   tx_valid      : one-cycle strobe, dout freshly loaded by a read
//   rd_addr_valid : a read address has been set and not yet consumed
// Optional feature: SPI_ADDR_AUTO_INC_EN -- post-increment wr_addr on each
// data write and rd_addr on each data read (wrapping at MEM_DEPTH-1), and
// keep rd_addr_valid set so reads can be issued back to back.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int PW         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PW+1:0]         din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  rd_addr_valid
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [1:0]            cmd;
  logic                  unused_din;

  assign cmd = din[PW+1:PW];
  // Payload MSBs above the address/data width are deliberately ignored.
  assign unused_din = ^din;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < AW1'(MEM_DEPTH);
  endfunction

  // Out-of-range addresses also fall back to 0 so a burst re-enters the RAM.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    if ({1'b0, a} >= AW1'(MEM_DEPTH - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CMD_WR_DATA && in_range(wr_addr))
      mem[wr_addr[IW-1:0]] <= din[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr       <= '0;
      rd_addr       <= '0;
      rd_addr_valid <= 1'b0;
      dout          <= '0;
      tx_valid      <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= din[ADDR_WIDTH-1:0];
          CMD_WR_DATA: begin
`ifdef SPI_ADDR_AUTO_INC_EN
            wr_addr <= addr_inc(wr_addr);
`endif
          end
          CMD_RD_ADDR: begin
            rd_addr       <= din[ADDR_WIDTH-1:0];
            rd_addr_valid <= 1'b1;
          end
          default: begin
            dout     <= in_range(rd_addr) ? mem[rd_addr[IW-1:0]] : '0;
            tx_valid <= 1'b1;
`ifdef SPI_ADDR_AUTO_INC_EN
            rd_addr <= addr_inc(rd_addr);
`else
            rd_addr_valid <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_slave_ram_param.sv
// Parametrised SPI slave fronting a single-port RAM.
//   clk, rst_n : system clock (rising edge), async active-low reset
//   bus        : spi_ram_if.slave (SS_n, MOSI in; MISO out)
// Frame: R/W bit, 2 cmd bits, PW payload bits, MSB first, one bit per clk
// while SS_n is low. Read data streams out on MISO two cycles after the
// last frame bit. Optional feature macro: SPI_ADDR_AUTO_INC_EN (see
// spi_ram_mem).
module spi_slave_ram_param
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input logic     clk,
  input logic     rst_n,
  spi_ram_if.slave bus
);

  localparam int PW = pw_of(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(PW + 3);
  localparam int TW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PW + 1);
  localparam logic [TW-1:0] TX_LOAD  = TW'(DATA_WIDTH - 1);

  state_t                state, state_nx;
  logic [PW+1:0]         rx_shift;
  logic [CW-1:0]         bit_cnt;
  logic                  frame_done;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout, tx_shift;
  logic                  tx_valid;
  logic [TW-1:0]         tx_cnt;
  logic                  miso_q;
  logic                  rd_addr_valid;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.SS_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = CHK_CMD;
        CHK_CMD: state_nx = bus.MOSI ? (rd_addr_valid ? READ_DATA : READ_ADD) : WRITE;
        default: state_nx = state;
      endcase
    end
  end

  // Receive: shift cmd + payload; once the frame is complete, ignore MOSI
  // until SS_n rises. The first cmd bit must agree with the R/W path
  // (0x on writes, 1x on reads), otherwise the frame is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift   <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bus.SS_n || state == IDLE || state == CHK_CMD) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else if (!frame_done) begin
        rx_shift <= {rx_shift[PW:0], bus.MOSI};
        bit_cnt  <= bit_cnt + CW'(1);
        if (bit_cnt == LAST_CNT) begin
          frame_done <= 1'b1;
          rx_valid   <= (rx_shift[PW] == (state != WRITE));
        end
      end
    end
  end

  // Transmit: tx_valid arrives one cycle after the RAM read; MSB goes out
  // immediately, the rest follow one per clock, then MISO idles low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q   <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
    end else if (bus.SS_n) begin
      miso_q <= 1'b0;
      tx_cnt <= '0;
    end else if (tx_valid) begin
      miso_q   <= dout[DATA_WIDTH-1];
      tx_shift <= dout << 1;
      tx_cnt   <= TX_LOAD;
    end else if (tx_cnt != '0) begin
      miso_q   <= tx_shift[DATA_WIDTH-1];
      tx_shift <= tx_shift << 1;
      tx_cnt   <= tx_cnt - TW'(1);
    end else begin
      miso_q <= 1'b0;
    end
  end

  assign bus.MISO = miso_q;

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (rx_shift),
    .rx_valid      (rx_valid),
    .dout          (dout),
    .tx_valid      (tx_valid),
    .rd_addr_valid (rd_addr_valid)
  );

endmodule
